// File: rtl/lc4_muldiv_iter.sv
// Iterative unsigned multiply / divide for the LC4 execute stage.
// One result bit per cycle; IDLE -> BUSY -> DONE with response backpressure and flush.
module lc4_muldiv_iter #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_resp_ready,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic             op_q;
  logic [TAG_W-1:0] tag_q;
  logic             dbz_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             accept;
  logic             dbz_req;
  logic             last_step;

  assign accept    = i_valid && (state == IDLE) && !i_flush;
  assign dbz_req   = !i_op && (i_b == '0);
  assign last_step = (cnt == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: flush outranks both completion and response acceptance
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept)            state_nxt = dbz_req ? DONE : BUSY;
      BUSY: if (i_flush)           state_nxt = IDLE;
            else if (last_step)    state_nxt = DONE;
      DONE: if (i_flush)           state_nxt = IDLE;
            else if (i_resp_ready) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from registered state only; results masked outside DONE
  always_comb begin
    o_ready       = (state == IDLE);
    o_valid       = (state == DONE);
    o_result_lo   = '0;
    o_result_hi   = '0;
    o_tag         = '0;
    o_div_by_zero = 1'b0;
    if (state == DONE) begin
      o_result_lo   = lo_q;
      o_result_hi   = hi_q;
      o_tag         = tag_q;
      o_div_by_zero = dbz_q;
    end
  end

  // One iteration step. hi_q/lo_q are {rem, quo} for DIV and the
  // {acc_hi, multiplier/acc_lo} shift pair for MUL.
  logic [WIDTH:0]   div_sh;
  logic [WIDTH+1:0] div_diff;
  logic             div_borrow;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] hi_n, lo_n;

  always_comb begin
    div_sh     = {hi_q, lo_q[WIDTH-1]};
    div_diff   = {1'b0, div_sh} - {2'b00, opnd_q};
    div_borrow = div_diff[WIDTH+1];
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    if (op_q) begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_n = div_borrow ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ~div_borrow};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= 1'b0;
      tag_q  <= '0;
      dbz_q  <= 1'b0;
      cnt    <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (accept) begin
      op_q   <= i_op;
      tag_q  <= i_tag;
      dbz_q  <= dbz_req;
      cnt    <= CW'(WIDTH);
      opnd_q <= i_op ? i_a : i_b;
      hi_q   <= '0;
      lo_q   <= dbz_req ? '0 : (i_op ? i_b : i_a);
    end else if (state == BUSY && !i_flush) begin
      cnt  <= cnt - CW'(1);
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

endmodule

// File: doc/lc4_muldiv_iter.md
# lc4_muldiv_iter

Multi-cycle iterative multiply/divide unit for the LC4 datapath. It replaces the single-cycle combinational divider and multiplier used for MUL, DIV and MOD. The unit is parametrised in operand width and result-tag width. It computes one result bit per cycle behind a request/response handshake with backpressure and flush. It sits beside the ALU in the execute stage, and the pipeline stalls on `o_ready`/`o_valid`.

## Interface
- `WIDTH`, default 16: operand and result width in bits. Must be at least 2.
- `TAG_W`, default 3: width of the opaque tag carried from request to response (destination register).
- `clk`  in  1: single clock. All state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `i_valid`  in  1: request present.
- `o_ready`  out  1: unit can accept a request. High only in IDLE.
- `i_op`  in  1: 0 = DIV/MOD, 1 = MUL.
- `i_a`  in  WIDTH: dividend or multiplicand (unsigned).
- `i_b`  in  WIDTH: divisor or multiplier (unsigned).
- `i_tag`  in  TAG_W: request tag.
- `i_flush`  in  1: abort any operation in flight.
- `o_valid`  out  1: result available.
- `i_resp_ready`  in  1: consumer accepts the result.
- `o_result_lo`  out  WIDTH: quotient (DIV) or low product half (MUL).
- `o_result_hi`  out  WIDTH: remainder (DIV) or high product half (MUL).
- `o_tag`  out  TAG_W: tag of the returned result.
- `o_div_by_zero`  out  1: DIV request had `i_b == 0`.

## Operation
- States: IDLE, BUSY, DONE. `o_ready = (state == IDLE)`. `o_valid = (state == DONE)`.
- **Accept:** `i_valid && o_ready && !i_flush` at an edge. On accept the unit latches `i_op`, `i_a`, `i_b`, `i_tag` and loads the step counter with WIDTH.
  - If DIV and `i_b == 0`: go directly to DONE with lo = 0, hi = 0, `o_div_by_zero = 1`. This is LC4 semantics.
  - Otherwise: go to BUSY.
- **BUSY:** one step per edge; the counter decrements.
  - DIV: unsigned restoring division. Shift {rem, quo} left one bit, trial-subtract the divisor, keep the result if it is non-negative and set the quotient LSB.
  - MUL: unsigned shift-add into a 2×WIDTH accumulator, consuming one multiplier bit per step.
  - The step that brings the counter to 0 also transitions to DONE.
- **Results:**
  - DIV: lo = floor(a/b), hi = a mod b.
  - MUL: {hi, lo} = a × b exactly (2×WIDTH bits). The LC4 MUL writeback uses lo.
- **DONE:** all outputs are held stable until `i_resp_ready` is high at an edge, then the unit returns to IDLE.
- **Flush:** `i_flush` high at an edge in BUSY or DONE returns the unit to IDLE and discards the result. Flush takes priority over `i_resp_ready` and over accept. `i_flush` in IDLE blocks acceptance that cycle.
- **Output masking:** `o_result_lo`, `o_result_hi`, `o_tag` and `o_div_by_zero` are 0 whenever `o_valid == 0`.
- **Reset:** state IDLE, counter 0, all registers 0. Outputs: `o_ready = 1`, `o_valid = 0`, all others 0. Reset mid-operation abandons the operation with no response.

## Timing
- **Latency:**
  - Request accepted at edge N (normal case): BUSY steps at edges N+1 … N+WIDTH, and `o_valid` is high from the cycle after edge N+WIDTH.
  - Divide-by-zero: `o_valid` is high in the cycle after edge N.
- **Earliest release:** the result is held while `i_resp_ready` is low. With `i_resp_ready` high on the first DONE cycle, DONE lasts one cycle and `o_ready` returns the following cycle.
- **Throughput:** one operation per WIDTH+2 cycles at best. There is no overlap: the next request cannot be accepted in the same cycle the response is accepted.
- **Combinational paths:** none from inputs to outputs; `o_ready`/`o_valid` are decoded from registered state only.
- **Critical path:** one WIDTH-bit subtract/add per cycle, with no wider combinational arithmetic.

## Test plan
- **DIV latency** (WIDTH=16): DIV a=100, b=7 accepted at edge N → `o_valid` first high after edge N+16; lo=14, hi=2, `o_div_by_zero`=0, `o_tag` equals the request tag.
- **Extremes:**
  - DIV 0xFFFF/1 → lo=0xFFFF, hi=0.
  - MUL 0xFFFF×0xFFFF → lo=0x0001, hi=0xFFFE.
  - MUL 0×1234 → lo=0, hi=0.
- **Divide by zero:** DIV 5/0 → `o_valid` in the cycle after accept; lo=0, hi=0, `o_div_by_zero`=1. `o_ready` stays 0 until the response is taken.
- **Backpressure:** hold `i_resp_ready`=0 for 5 DONE cycles → `o_valid` and all outputs stay stable and `o_ready`=0 throughout. Raise `i_resp_ready` → IDLE next cycle; a new request is then accepted.
- **Flush:** assert `i_flush` at the 8th BUSY edge → `o_valid` never rises and `o_ready`=1 next cycle. A follow-up DIV 9/3 returns lo=3, hi=0. Repeat the flush in DONE and in IDLE with `i_valid`=1 → no accept that cycle.
- **Reset and width:** assert `rst` mid-BUSY → next cycle `o_ready`=1, `o_valid`=0, outputs 0. With WIDTH=8, DIV 200/13 → lo=15, hi=5, `o_valid` after edge N+8.
